pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
//  Successor to the fixed-field inter-stage registers (IF/ID ... MEM/WB).
//  - Fixed signal list replaced by two packed buses: control and datapath.
//  - Adds backpressure without a combinational ready path, a flush that beats stall, and a stall counter.
//  - Sits between any two CPU stages; one instance per stage boundary.
// PARAMETERS
//  CTRL_W         24  width of packed control bundle (decoder flags, ALU_OP, Mode ...)
//  DATA_W         165 width of packed datapath bundle (instr, PC+4, ALU results, RD, dest reg ...)
//  CNT_W          16  width of saturating stall counter
//  ZERO_ON_BUBBLE 1   1: out_ctrl/out_data read 0 while out_valid=0; 0: hold last value
// PORTS
//  clk        in  1       rising-edge clock
//  clr        in  1       reset: synchronous, active-high (highest priority)
//  flush      in  1       synchronous kill of all held entries (branch/jump/exception)
//  in_valid   in  1       upstream has an entry
//  in_ready   out 1       stage can accept; registered (no comb path from out_ready)
//  in_ctrl    in  CTRL_W  upstream control bundle
//  in_data    in  DATA_W  upstream datapath bundle
//  out_valid  out 1       main slot holds an entry
//  out_ready  in  1       downstream accepts
//  out_ctrl   out CTRL_W  main-slot control bundle
//  out_data   out DATA_W  main-slot datapath bundle
//  occupancy  out 2       entries held: 0, 1 or 2
//  stall_cnt  out CNT_W   cycles with out_valid=1 and out_ready=0; saturates at all-ones
// BEHAVIOUR
//  - Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready (sampled at posedge clk).
//  - Storage: main slot (drives outputs) and skid slot.
//    - in_ready = ~skid_valid & ~clr_q, where clr_q is a flop set by clr.
//    - Latency: an entry accepted into an empty stage appears on out_* the next cycle.
//  - States (occupancy):
//    - EMPTY (0):
//      - in_fire -> ONE, main<=in.
//    - ONE (1):
//      - in_fire & out_fire -> ONE, main<=in.
//      - in_fire only -> FULL, skid<=in.
//      - out_fire only -> EMPTY.
//      - neither -> ONE, hold.
//    - FULL (2): in_ready=0.
//      - out_fire -> ONE, main<=skid.
//      - else hold.
//  - Ordering: entries leave in acceptance order; no entry is duplicated or dropped except by flush/clr.
//  - flush (clr=0): next state EMPTY and both valids cleared.
//    - An in_fire in the same cycle is discarded.
//    - An out_fire in the same cycle still counts as delivered downstream.
//    - stall_cnt is unaffected.
//  - clr: next cycle all outputs 0 and in_ready=0. This includes out_valid, occupancy, stall_cnt,
//    out_ctrl and out_data, and skid contents are zeroed.
//    - The cycle after clr deasserts, in_ready=1.
//    - clr mid-transfer drops all entries.
//  - ZERO_ON_BUBBLE=1: out_ctrl/out_data are 0 whenever out_valid=0, so a bubble decodes as NOP
//    (all write enables low).
//  - stall_cnt increments by 1 when out_valid & ~out_ready, and holds at 2^CNT_W-1.
//  - Priority: clr > flush > handshake.
//  - No X may reach out_* after the first clr cycle.
// STRUCTURE
//  - Shared package pipe_pkg: occupancy localparams OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
//  - Default CTRL_W/DATA_W values also live in pipe_pkg; per-stage bundle offsets are defined there
//    as well so decode/ALU/MEM/WB agree.
//  - One sub-module is natural: pipe_slot (valid + ctrl + data flop with load/clear), instanced
//    twice (main, skid).
//  - FSM and counter stay in the top.
// TESTING
//  1. clr=1 for 2 cycles, then low:
//     - out_valid=0, occupancy=0, stall_cnt=0 and out_data=0 during clr.
//     - in_ready=1 the cycle after release.
//  2. out_ready=1, in_valid=1 on consecutive cycles with data 0x1,0x2,0x3:
//     - out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1.
//  3. Load 0xA, then out_ready=0 while 0xB offered:
//     - occupancy=2, in_ready=0, stall_cnt counts 1,2,3.
//     - Raise out_ready: 0xA then 0xB emerge, in_ready returns to 1.
//  4. FULL with 0xA/0xB, assert flush with in_valid=1 data 0xC:
//     - Next cycle occupancy=0, out_valid=0, out_data=0 (ZERO_ON_BUBBLE=1), 0xC never appears.
//  5. CNT_W=4, out_ready held 0 for 20 cycles with an entry held:
//     - stall_cnt reaches 15 and stays 15.
//  6. clr asserted while occupancy=2 and flush=1 simultaneously:
//     - Next cycle all outputs 0 and in_ready=0.
//     - After release, a fresh entry 0x5 passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: occupancy encoding,
// default bundle widths and the field layout of the control/datapath bundles.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_t;

  localparam int CTRL_W_DEF = 24;
  localparam int DATA_W_DEF = 165;

  // Control bundle layout; every write enable sits low so an all-zero bundle is a NOP.
  localparam int CTRL_REG_WE_BIT  = 0;
  localparam int CTRL_MEM_WE_BIT  = 1;
  localparam int CTRL_MEM_RD_BIT  = 2;
  localparam int CTRL_BRANCH_BIT  = 3;
  localparam int CTRL_ALU_OP_LSB  = 4;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_MODE_LSB    = 8;
  localparam int CTRL_MODE_W      = 4;

  // Datapath bundle layout.
  localparam int DATA_INSTR_LSB   = 0;
  localparam int DATA_PC4_LSB     = 32;
  localparam int DATA_ALU_LSB     = 64;
  localparam int DATA_RD_LSB      = 96;
  localparam int DATA_MEM_LSB     = 128;
  localparam int DATA_DEST_LSB    = 160;
  localparam int DATA_DEST_W      = 5;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid flag plus control and datapath bundles.
module pipe_slot #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 165
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // clear zeroes the payload too; drop only invalidates so the payload can be held.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with registered valid/ready handshake, 2-entry skid
// buffer, flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W         = CTRL_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CNT_W          = 16,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on flops, never on out_ready.
  occ_t              state_q, state_d;
  logic              clr_q;
  logic              in_fire, out_fire;
  logic              main_load, main_from_skid, main_drop;
  logic              skid_load, skid_drop;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;

  assign in_ready  = ~skid_valid & ~clr_q;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign occupancy = state_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_EMPTY;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_d = ST_FULL;
        else if (!in_fire && out_fire) state_d = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush) begin
      main_drop = 1'b1;
      skid_drop = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire) main_load = 1'b1;
          else if (in_fire)        skid_load = 1'b1;
          else if (out_fire)       main_drop = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
          end
        end
        default: begin
          main_drop = 1'b1;
          skid_drop = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .clear  (clr),
    .load   (main_load),
    .drop   (main_drop),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .clear  (clr),
    .load   (skid_load),
    .drop   (skid_drop),
    .ctrl_d (in_ctrl),
    .data_d (in_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  // A bubble reads as all-zero so downstream decodes it as a NOP.
  assign out_ctrl = (ZERO_ON_BUBBLE && !main_valid) ? '0 : main_ctrl;
  assign out_data = (ZERO_ON_BUBBLE && !main_valid) ? '0 : main_data;

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios, random traffic
// and a scoreboard queue of accepted entries.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 24;
  localparam int DATA_W = 165;
  localparam int CNT_W  = 16;
  localparam int W      = CTRL_W + DATA_W;

  logic              clk;
  logic              clr;
  logic              flush;
  logic              in_valid;
  logic              in_ready, in_ready4;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_valid4;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl, out_ctrl4;
  logic [DATA_W-1:0] out_data, out_data4;
  logic [1:0]        occupancy, occupancy4;
  logic [CNT_W-1:0]  stall_cnt;
  logic [3:0]        stall_cnt4;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ZERO_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4), .ZERO_ON_BUBBLE(1'b1)) dut4 (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [DATA_W-1:0] d);
    return {8'h5a, d[15:0] ^ 16'h3c3c};
  endfunction

  task automatic drive_in(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = mk_ctrl(d);
  endtask

  // Called at a negedge with inputs already set: score this cycle, then advance.
  task automatic tick();
    if (!out_valid)
      check("bubble_zero", {out_ctrl, out_data}, '0);
    if (out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) check("unexpected_out", {out_ctrl, out_data}, '0);
      else                   check("sb_entry", {out_ctrl, out_data}, exp_q.pop_front());
    end
    if (in_valid && in_ready && !clr && !flush)
      exp_q.push_back({in_ctrl, in_data});
    if (clr || flush)
      exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [191:0] r;
    clr = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, '0);

    // 1: two cycles of clr, then release
    @(negedge clk);
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_occ", occupancy, 2'd0);
    check("clr_stall", stall_cnt, '0);
    check("clr_out_data", out_data, '0);
    check("clr_in_ready", in_ready, 1'b0);
    tick();
    check("clr2_in_ready", in_ready, 1'b0);
    clr = 1'b0;
    tick();
    check("release_in_ready", in_ready, 1'b1);

    // 2: streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_in(1'b1, DATA_W'(i));
      tick();
      check("stream_occ", occupancy, 2'd1);
      check("stream_data", out_data, DATA_W'(i));
    end
    drive_in(1'b0, '0);
    tick();
    check("stream_drained", occupancy, 2'd0);

    // 3: backpressure into the skid slot
    out_ready = 1'b0;
    drive_in(1'b1, DATA_W'('hA));
    tick();
    check("bp_occ1", occupancy, 2'd1);
    check("bp_stall0", stall_cnt, CNT_W'(0));
    drive_in(1'b1, DATA_W'('hB));
    tick();
    drive_in(1'b0, '0);
    check("bp_occ2", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_stall1", stall_cnt, CNT_W'(1));
    tick();
    check("bp_stall2", stall_cnt, CNT_W'(2));
    tick();
    check("bp_stall3", stall_cnt, CNT_W'(3));
    check("bp_head", out_data, DATA_W'('hA));
    out_ready = 1'b1;
    tick();
    check("bp_next", out_data, DATA_W'('hB));
    check("bp_in_ready_back", in_ready, 1'b1);
    check("bp_occ_one", occupancy, 2'd1);
    tick();
    check("bp_empty", occupancy, 2'd0);
    check("bp_stall_hold", stall_cnt, CNT_W'(3));

    // 4: flush of a full stage with a simultaneous offer
    out_ready = 1'b0;
    drive_in(1'b1, DATA_W'('hA));
    tick();
    drive_in(1'b1, DATA_W'('hB));
    tick();
    check("fl_full", occupancy, 2'd2);
    flush = 1'b1;
    drive_in(1'b1, DATA_W'('hC));
    tick();
    flush = 1'b0;
    drive_in(1'b0, '0);
    check("fl_occ", occupancy, 2'd0);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_out_data", out_data, '0);
    check("fl_stall_kept", stall_cnt, CNT_W'(5));
    check("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_c", out_valid, 1'b0);
    end

    // 5: stall counter saturation (4-bit instance)
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    out_ready = 1'b0;
    drive_in(1'b1, DATA_W'('h77));
    tick();
    drive_in(1'b0, '0);
    check("sat_start", stall_cnt4, 4'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_reach15", stall_cnt4, 4'd15);
    end
    check("sat_hold15", stall_cnt4, 4'd15);
    check("sat_wide20", stall_cnt, CNT_W'(20));

    // 6: clr together with flush while full, then a fresh entry
    drive_in(1'b1, DATA_W'('hB));
    tick();
    drive_in(1'b0, '0);
    check("cf_full", occupancy, 2'd2);
    clr = 1'b1;
    flush = 1'b1;
    tick();
    clr = 1'b0;
    flush = 1'b0;
    check("cf_out_valid", out_valid, 1'b0);
    check("cf_occ", occupancy, 2'd0);
    check("cf_stall", stall_cnt, '0);
    check("cf_stall4", stall_cnt4, 4'd0);
    check("cf_out", {out_ctrl, out_data}, '0);
    check("cf_in_ready", in_ready, 1'b0);
    tick();
    check("cf_release_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    drive_in(1'b1, DATA_W'('h5));
    tick();
    drive_in(1'b0, '0);
    check("cf_fresh_valid", out_valid, 1'b1);
    check("cf_fresh_data", out_data, DATA_W'('h5));
    tick();

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive_in(1'($urandom_range(0, 1)), r[DATA_W-1:0]);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0;
    drive_in(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    check("drain_out_valid", out_valid, 1'b0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
